// File: rtl/seq_datapath.sv
// seq_datapath: multi-cycle register-file datapath.
// A small FSM sequences operand loads (B then A), one ALU step into C/status,
// and a write-back into the register file. Mode selects which steps run.
module seq_datapath #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [1:0]               op,
    input  logic [1:0]               shift,
    input  logic [$clog2(NREG)-1:0]  rd,
    input  logic [$clog2(NREG)-1:0]  rn,
    input  logic [$clog2(NREG)-1:0]  rm,
    input  logic [DATA_W-1:0]        imm,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        datapath_out,
    output logic [2:0]               status_out
);
    localparam int REG_AW = $clog2(NREG);

    localparam logic [1:0] MODE_ALU_REG = 2'b00;
    localparam logic [1:0] MODE_ALU_IMM = 2'b01;
    localparam logic [1:0] MODE_MOV     = 2'b10;
    localparam logic [1:0] MODE_CMP     = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADB = 3'd1,
        LOADA = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4
    } state_t;

    state_t              state_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [1:0]          mode_reg;
    logic [1:0]          op_reg;
    logic [1:0]          shift_reg;
    logic [REG_AW-1:0]   rd_reg;
    logic [REG_AW-1:0]   rn_reg;
    logic [REG_AW-1:0]   rm_reg;
    logic [DATA_W-1:0]   imm_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   c_reg;
    logic [2:0]          status_reg;
    logic [DATA_W-1:0]   regs_reg [NREG];

    logic [DATA_W-1:0]   b_src;
    logic [DATA_W-1:0]   b_sh;
    logic [1:0]          alu_op;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_v;
    logic                wr_en;
    logic [DATA_W-1:0]   wb_data;

    // ALU: shifted B operand (register or immediate), op select, {N,V,Z} flags.
    always_comb begin
        b_src   = (mode_reg == MODE_ALU_IMM) ? imm_reg : b_reg;
        b_sh    = b_src;
        alu_res = '0;
        alu_v   = 1'b0;
        case (shift_reg)
            2'b01:   b_sh = {b_src[DATA_W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_src[DATA_W-1:1]};
            2'b11:   b_sh = {b_src[DATA_W-1], b_src[DATA_W-1:1]};
            default: b_sh = b_src;
        endcase
        // Compare always subtracts, regardless of the op field.
        alu_op = (mode_reg == MODE_CMP) ? OP_SUB : op_reg;
        case (alu_op)
            OP_ADD: begin
                alu_res = a_reg + b_sh;
                alu_v   = (a_reg[DATA_W-1] == b_sh[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_reg[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = a_reg - b_sh;
                alu_v   = (a_reg[DATA_W-1] != b_sh[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_reg[DATA_W-1]);
            end
            OP_AND:  alu_res = a_reg & b_sh;
            default: alu_res = ~b_sh;
        endcase
    end

    assign wr_en   = (state_reg == WB);
    assign wb_data = (mode_reg == MODE_MOV) ? imm_reg : c_reg;

    // Sequencer: latches the request, walks the mode's state path, owns A/B/C/status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            mode_reg   <= '0;
            op_reg     <= '0;
            shift_reg  <= '0;
            rd_reg     <= '0;
            rn_reg     <= '0;
            rm_reg     <= '0;
            imm_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            status_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        op_reg    <= op;
                        shift_reg <= shift;
                        rd_reg    <= rd;
                        rn_reg    <= rn;
                        rm_reg    <= rm;
                        imm_reg   <= imm;
                        busy_reg  <= 1'b1;
                        case (mode)
                            MODE_ALU_REG, MODE_CMP: state_reg <= LOADB;
                            MODE_ALU_IMM:           state_reg <= LOADA;
                            default:                state_reg <= WB;
                        endcase
                    end
                end
                LOADB: begin
                    b_reg     <= regs_reg[rm_reg];
                    state_reg <= LOADA;
                end
                LOADA: begin
                    a_reg     <= regs_reg[rn_reg];
                    state_reg <= EXEC;
                end
                EXEC: begin
                    c_reg      <= alu_res;
                    status_reg <= {alu_res[DATA_W-1], alu_v, (alu_res == '0)};
                    if (mode_reg == MODE_CMP) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= WB;
                    end
                end
                WB: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Register file: one flop row per register, written only in WB.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en && (rd_reg == REG_AW'(gi))) begin
                    regs_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    assign dbg_data     = regs_reg[dbg_addr];
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign datapath_out = c_reg;
    assign status_out   = status_reg;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed operation list, a behavioural model of the
// register file / C / status, a per-cycle compare process, and literal pins.
module tb_seq_datapath;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode, op, shift;
    logic [AW-1:0] rd, rn, rm, dbg_addr;
    logic [W-1:0]  imm, dbg_data, datapath_out;
    logic          busy, done;
    logic [2:0]    status_out;

    // second instance for the wide configuration
    logic          start32;
    logic [1:0]    mode32, op32, shift32;
    logic [3:0]    rd32, rn32, rm32, dbg_addr32;
    logic [31:0]   imm32, dbg_data32, datapath_out32;
    logic          busy32, done32;
    logic [2:0]    status_out32;

    always #5 clk = ~clk;

    seq_datapath #(.DATA_W(W), .NREG(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op(op), .shift(shift),
        .rd(rd), .rn(rn), .rm(rm), .imm(imm), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done), .datapath_out(datapath_out), .status_out(status_out)
    );

    seq_datapath #(.DATA_W(32), .NREG(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32), .op(op32), .shift(shift32),
        .rd(rd32), .rn(rn32), .rm(rm32), .imm(imm32), .dbg_addr(dbg_addr32), .dbg_data(dbg_data32),
        .busy(busy32), .done(done32), .datapath_out(datapath_out32), .status_out(status_out32)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_regs [N];
    logic [W-1:0] exp_c;
    logic [2:0]   exp_status;
    logic         exp_busy, exp_done;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected {N,V,Z,result} from the arithmetic meaning of the operation.
    function automatic logic [W+2:0] model_alu(input logic [1:0] m, input logic [1:0] o,
                                               input logic [1:0] s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] bs, r;
        logic [1:0]   eo;
        longint       sa, sb, full, lim;
        logic         v;
        case (s)
            2'd1:    bs = W'(b * 2);
            2'd2:    bs = b / 2;
            2'd3:    bs = b / 2 + (b[W-1] ? W'(2 ** (W - 1)) : W'(0));
            default: bs = b;
        endcase
        eo  = (m == 2'd3) ? 2'd1 : o;
        sa  = longint'($signed(a));
        sb  = longint'($signed(bs));
        lim = longint'(1) <<< (W - 1);
        v   = 1'b0;
        case (eo)
            2'd0: begin full = sa + sb; r = full[W-1:0]; v = (full >= lim) || (full < -lim); end
            2'd1: begin full = sa - sb; r = full[W-1:0]; v = (full >= lim) || (full < -lim); end
            2'd2: r = a & bs;
            default: r = ~bs;
        endcase
        return {r[W-1], v, (r == 0), r};
    endfunction

    // Every cycle: control outputs, C, status and the debug read port vs the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("datapath_out", 64'(datapath_out), 64'(exp_c));
            check("status_out", 64'(status_out), 64'(exp_status));
            check("dbg_data", 64'(dbg_data), 64'(model_regs[dbg_addr]));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_done = 1'b0;
        end
    endtask

    // Issue one operation starting at posedge+1; returns at posedge+1 with done expected high.
    // pulse_k: raise a (bogus) start for one cycle at step k; abort_k: assert reset at step k.
    task automatic do_op(input logic [1:0] m, input logic [1:0] o, input logic [1:0] s,
                         input logic [AW-1:0] d, input logic [AW-1:0] a_i,
                         input logic [AW-1:0] b_i, input logic [W-1:0] im,
                         input int pulse_k, input int abort_k);
        logic [W+2:0] res;
        int lat, cx;
        mode = m; op = o; shift = s; rd = d; rn = a_i; rm = b_i; imm = im;
        dbg_addr = d; start = 1'b1;
        res = model_alu(m, o, s, model_regs[a_i], (m == 2'd1) ? im : model_regs[b_i]);
        case (m)
            2'd0: begin lat = 4; cx = 3; end
            2'd1: begin lat = 3; cx = 2; end
            2'd3: begin lat = 3; cx = 3; end
            default: begin lat = 1; cx = 0; end
        endcase
        @(posedge clk); #1;
        start = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == pulse_k) begin
                start = 1'b1; mode = 2'd2; rd = 3'd7; imm = 16'h5555;
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                for (int i = 0; i < N; i++) model_regs[i] = '0;
                exp_c = '0; exp_status = '0; exp_busy = 1'b0; exp_done = 1'b0;
                #1;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_c", 64'(datapath_out), 64'd0);
                check("abort_status", 64'(status_out), 64'd0);
                check("abort_rd", 64'(dbg_data), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k == cx) begin
                exp_c = res[W-1:0];
                exp_status = res[W+2:W];
            end
            if (k == lat) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                if (m != 2'd3) model_regs[d] = (m == 2'd2) ? im : res[W-1:0];
            end
        end
    endtask

    task automatic peek(input logic [AW-1:0] a, input logic [W-1:0] v, input string name);
        dbg_addr = a; #1;
        check(name, 64'(dbg_data), 64'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = '0; op = '0; shift = '0;
        rd = '0; rn = '0; rm = '0; imm = '0; dbg_addr = '0;
        start32 = 1'b0; mode32 = '0; op32 = '0; shift32 = '0;
        rd32 = '0; rn32 = '0; rm32 = '0; imm32 = '0; dbg_addr32 = '0;
        for (int i = 0; i < N; i++) model_regs[i] = '0;
        exp_c = '0; exp_status = '0; exp_busy = 1'b0; exp_done = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_c", 64'(datapath_out), 64'd0);
        check("rst_status", 64'(status_out), 64'd0);
        for (int i = 0; i < N; i++) begin
            dbg_addr = AW'(i); #1;
            check("rst_reg", 64'(dbg_data), 64'd0);
        end
        rst_n = 1'b1;
        chk_en = 1'b1;
        $display("reset released");

        // MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL1 (back-to-back, start during done)
        do_op(2'd2, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd7, 0, 0);
        $display("MOV R0,#7");
        do_op(2'd2, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'd2, 0, 0);
        $display("MOV R1,#2");
        do_op(2'd0, 2'd0, 2'd1, 3'd2, 3'd1, 3'd0, 16'd0, 0, 0);
        $display("ADD R2,R1,R0,LSL1 -> %0h status %b", datapath_out, status_out);
        check("add_lsl_c", 64'(datapath_out), 64'd16);
        check("add_lsl_status", 64'(status_out), 64'd0);
        peek(3'd2, 16'd16, "add_lsl_r2");
        idle(1);

        // MOV R3,#32; SUB R4,R2,R3,LSR1
        do_op(2'd2, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 16'd32, 0, 0);
        $display("MOV R3,#32");
        do_op(2'd0, 2'd1, 2'd2, 3'd4, 3'd2, 3'd3, 16'd0, 0, 0);
        $display("SUB R4,R2,R3,LSR1 -> %0h status %b", datapath_out, status_out);
        check("sub_c", 64'(datapath_out), 64'd0);
        check("sub_status", 64'(status_out), 64'b001);
        peek(3'd4, 16'd0, "sub_r4");
        idle(2);

        // MOV R0,#1; MOV R1,#0x8000; CMP R0,R1 (op field set to AND: CMP must still subtract)
        do_op(2'd2, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd1, 0, 0);
        do_op(2'd2, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'h8000, 0, 0);
        do_op(2'd3, 2'd2, 2'd0, 3'd5, 3'd0, 3'd1, 16'd0, 0, 0);
        $display("CMP R0,R1 -> %0h status %b", datapath_out, status_out);
        check("cmp_c", 64'(datapath_out), 64'h8001);
        check("cmp_status", 64'(status_out), 64'b110);
        peek(3'd5, 16'd0, "cmp_no_write");
        idle(1);

        // MOV R5,#0xFFCE; ADD R6,R7,R5,ASR1 then LSR1
        do_op(2'd2, 2'd0, 2'd0, 3'd5, 3'd0, 3'd0, 16'hFFCE, 0, 0);
        do_op(2'd0, 2'd0, 2'd3, 3'd6, 3'd7, 3'd5, 16'd0, 0, 0);
        $display("ADD R6,R7,R5,ASR1 -> %0h status %b", datapath_out, status_out);
        check("asr_status", 64'(status_out), 64'b100);
        peek(3'd6, 16'hFFE7, "asr_r6");
        idle(1);
        do_op(2'd0, 2'd0, 2'd2, 3'd6, 3'd7, 3'd5, 16'd0, 0, 0);
        $display("ADD R6,R7,R5,LSR1 -> %0h status %b", datapath_out, status_out);
        check("lsr_status", 64'(status_out), 64'b000);
        peek(3'd6, 16'h7FE7, "lsr_r6");
        idle(1);

        // More patterns, checked by the per-cycle model
        do_op(2'd1, 2'd0, 2'd0, 3'd3, 3'd1, 3'd0, 16'hFFFF, 0, 0);
        $display("ADDI R3,R1,#-1 -> %0h status %b", datapath_out, status_out);
        check("addi_ovf_status", 64'(status_out), 64'b010);
        do_op(2'd2, 2'd0, 2'd0, 3'd2, 3'd0, 3'd0, 16'h7FFF, 0, 0);
        do_op(2'd1, 2'd0, 2'd0, 3'd4, 3'd2, 3'd0, 16'd1, 0, 0);
        $display("ADDI R4,R2,#1 -> %0h status %b", datapath_out, status_out);
        check("addi_ovf2_c", 64'(datapath_out), 64'h8000);
        check("addi_ovf2_status", 64'(status_out), 64'b110);
        do_op(2'd1, 2'd2, 2'd1, 3'd0, 3'd5, 3'd0, 16'h00F0, 0, 0);
        $display("ANDI R0,R5,#0xF0 LSL1 -> %0h status %b", datapath_out, status_out);
        do_op(2'd0, 2'd3, 2'd0, 3'd1, 3'd2, 3'd6, 16'd0, 0, 0);
        $display("MVN R1,R6 -> %0h status %b", datapath_out, status_out);
        do_op(2'd0, 2'd0, 2'd0, 3'd2, 3'd2, 3'd2, 16'd0, 0, 0);
        $display("ADD R2,R2,R2 -> %0h status %b", datapath_out, status_out);
        check("rd_eq_src", 64'(datapath_out), 64'hFFFE);
        idle(2);

        // start pulsed during LOADA must be ignored
        do_op(2'd0, 2'd0, 2'd0, 3'd3, 3'd1, 3'd0, 16'd0, 2, 0);
        $display("ADD R3,R1,R0 with stray start");
        idle(4);
        peek(3'd7, 16'd0, "stray_start_r7");

        // reset during LOADA aborts, next op accepted on first edge
        do_op(2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'd0, 0, 2);
        $display("ADD aborted by reset");
        do_op(2'd2, 2'd0, 2'd0, 3'd2, 3'd0, 3'd0, 16'h1234, 0, 0);
        $display("MOV R2,#0x1234 after reset");
        check("post_reset_done", 64'(done), 64'd1);
        idle(2);
        for (int i = 0; i < N; i++) begin
            dbg_addr = AW'(i); #1;
            check("final_reg", 64'(dbg_data), 64'(model_regs[i]));
        end
        chk_en = 1'b0;

        // Wide configuration: MOV R15,#-1; ADDI R14,R15,#1
        @(posedge clk); #1;
        mode32 = 2'd2; rd32 = 4'd15; imm32 = 32'hFFFFFFFF; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        @(posedge clk); #1;
        check("w32_mov_done", 64'(done32), 64'd1);
        mode32 = 2'd1; op32 = 2'd0; shift32 = 2'd0; rd32 = 4'd14; rn32 = 4'd15;
        imm32 = 32'd1; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("w32_done_timing", 64'(done32), (k == 3) ? 64'd1 : 64'd0);
        end
        dbg_addr32 = 4'd14; #1;
        $display("W32 ADDI R14,R15,#1 -> R14=%0h status %b", dbg_data32, status_out32);
        check("w32_r14", 64'(dbg_data32), 64'd0);
        check("w32_status", 64'(status_out32), 64'b001);
        check("w32_c", 64'(datapath_out32), 64'd0);
        dbg_addr32 = 4'd15; #1;
        check("w32_r15", 64'(dbg_data32), 64'hFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
